// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file sequencer and its ALU.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_IDX_WIDTH  = 2;

    typedef enum logic [1:0] {
        OP_LDI = 2'd0,
        OP_MOV = 2'd1,
        OP_ADD = 2'd2,
        OP_SUB = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ1 = 2'd1,
        READ2 = 2'd2,
        WRITE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/regfile_alu.sv
// Combinational result/carry for the four sequencer operations.
module regfile_alu
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_opa,
    input  logic [DATA_WIDTH-1:0] i_opb,
    input  logic [DATA_WIDTH-1:0] i_imm,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_carry
);

    logic [DATA_WIDTH:0] w_sum;
    logic [DATA_WIDTH:0] w_diff;

    // The extra top bit is carry-out for ADD and borrow (opA < opB) for SUB.
    assign w_sum  = {1'b0, i_opa} + {1'b0, i_opb};
    assign w_diff = {1'b0, i_opa} - {1'b0, i_opb};

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (op_t'(i_op))
            OP_LDI: o_result = i_imm;
            OP_MOV: o_result = i_opa;
            OP_ADD: {o_carry, o_result} = w_sum;
            OP_SUB: {o_carry, o_result} = w_diff;
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Accepts register-transfer commands, sequences single-port register-file
// reads, and issues the write-back with a coincident result pulse.
module regfile_op_sequencer
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [IDX_WIDTH-1:0]  cmd_rd,
    input  logic [IDX_WIDTH-1:0]  cmd_rs1,
    input  logic [IDX_WIDTH-1:0]  cmd_rs2,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [IDX_WIDTH-1:0]  rf_read_index,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic [IDX_WIDTH-1:0]  rf_write_index,
    output logic                  rf_write_enable,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  res_valid,
    output logic                  carry
);

    seq_state_t            r_state;
    seq_state_t            w_next;
    op_t                   r_op;
    logic [IDX_WIDTH-1:0]  r_rd;
    logic [IDX_WIDTH-1:0]  r_rs1;
    logic [IDX_WIDTH-1:0]  r_rs2;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [DATA_WIDTH-1:0] r_opa;
    logic [DATA_WIDTH-1:0] r_opb;
    logic                  r_carry;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_alu_carry;
    logic                  w_accept;

    assign w_accept = cmd_valid && (r_state == IDLE);
    assign carry    = r_carry;

    regfile_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .i_op    (r_op),
        .i_opa   (r_opa),
        .i_opb   (r_opb),
        .i_imm   (r_imm),
        .o_result(w_result),
        .o_carry (w_alu_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        cmd_ready       = 1'b0;
        rf_read_index   = '0;
        rf_write_index  = '0;
        rf_write_enable = 1'b0;
        rf_write_data   = '0;
        res_valid       = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    w_next = (op_t'(cmd_op) == OP_LDI) ? WRITE : READ1;
            end
            READ1: begin
                rf_read_index = r_rs1;
                w_next        = (r_op == OP_MOV) ? WRITE : READ2;
            end
            READ2: begin
                rf_read_index = r_rs2;
                w_next        = WRITE;
            end
            WRITE: begin
                rf_write_enable = 1'b1;
                rf_write_index  = r_rd;
                rf_write_data   = w_result;
                res_valid       = 1'b1;
                w_next          = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= OP_LDI;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_imm   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op_t'(cmd_op);
                r_rd  <= cmd_rd;
                r_rs1 <= cmd_rs1;
                r_rs2 <= cmd_rs2;
                r_imm <= cmd_imm;
            end
            if (r_state == READ1) r_opa <= rf_read_data;
            if (r_state == READ2) r_opb <= rf_read_data;
            // Carry only tracks arithmetic results; LDI/MOV keep the old flag.
            if (r_state == WRITE && (r_op == OP_ADD || r_op == OP_SUB))
                r_carry <= w_alu_carry;
        end
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer with an attached register-file model and a
// transaction-level reference model checked every cycle.
module tb_regfile_op_sequencer;

    localparam int DW = 16;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [IW-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [DW-1:0] cmd_imm = '0;
    logic [IW-1:0] rf_read_index, rf_write_index;
    logic [DW-1:0] rf_read_data, rf_write_data;
    logic          rf_write_enable, res_valid, carry;

    regfile_op_sequencer #(
        .DATA_WIDTH(DW),
        .IDX_WIDTH (IW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_rd         (cmd_rd),
        .cmd_rs1        (cmd_rs1),
        .cmd_rs2        (cmd_rs2),
        .cmd_imm        (cmd_imm),
        .rf_read_index  (rf_read_index),
        .rf_read_data   (rf_read_data),
        .rf_write_index (rf_write_index),
        .rf_write_enable(rf_write_enable),
        .rf_write_data  (rf_write_data),
        .res_valid      (res_valid),
        .carry          (carry)
    );

    always #5 clk = ~clk;

    // Attached register file: combinational read, write on rising edge.
    logic [DW-1:0] rf [4] = '{default: '0};
    assign rf_read_data = rf[rf_read_index];
    always @(posedge clk) if (rf_write_enable) rf[rf_write_index] <= rf_write_data;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    endtask

    // Reference model: whole-command view (accept time, write time, value).
    int unsigned   cyc = 0;
    int unsigned   m_ready_at = 0, m_acc_at = 0, m_wr_at = 0;
    bit            m_pend = 0;
    bit            m_carry = 0, m_cnext = 0;
    logic [1:0]    m_op = '0;
    logic [IW-1:0] m_rd = '0, m_rs1 = '0, m_rs2 = '0;
    logic [DW-1:0] m_val = '0;
    logic [DW-1:0] m_regs [4] = '{default: '0};

    always @(posedge clk) begin
        int unsigned k, lat;
        logic [DW-1:0] a, b;
        logic [DW:0]   s;
        if (reset) begin
            m_pend     = 0;
            m_carry    = 0;
            m_ready_at = 0;
        end else begin
            if (m_pend && cyc == m_wr_at) begin
                m_regs[m_rd] = m_val;
                if (m_op >= 2'd2) m_carry = m_cnext;
                m_pend = 0;
            end
            if (cmd_valid && cyc >= m_ready_at) begin
                k = cyc + 1;
                a = m_regs[cmd_rs1];
                b = m_regs[cmd_rs2];
                m_op = cmd_op; m_rd = cmd_rd; m_rs1 = cmd_rs1; m_rs2 = cmd_rs2;
                m_cnext = 0;
                case (cmd_op)
                    2'd0: begin m_val = cmd_imm; lat = 1; end
                    2'd1: begin m_val = a; lat = 2; end
                    2'd2: begin s = a + b; m_val = s[DW-1:0]; m_cnext = s[DW]; lat = 3; end
                    default: begin m_val = a - b; m_cnext = (a < b); lat = 3; end
                endcase
                m_acc_at   = k;
                m_wr_at    = k + lat - 1;
                m_ready_at = k + lat;
                m_pend     = 1;
            end
        end
        cyc = cyc + 1;
    end

    logic [DW-1:0] strobe_q [$];

    always @(negedge clk) begin
        bit            e_we;
        logic [IW-1:0] e_ridx;
        if (reset) begin
            chk("rst_outs", {rf_write_enable, res_valid, rf_write_index, rf_write_data,
                             rf_read_index, carry}, '0);
        end else begin
            e_we   = m_pend && cyc == m_wr_at;
            e_ridx = '0;
            if (m_pend && m_op != 2'd0 && cyc == m_acc_at) e_ridx = m_rs1;
            else if (m_pend && m_op >= 2'd2 && cyc == m_acc_at + 1) e_ridx = m_rs2;
            chk("cmd_ready", cmd_ready, cyc >= m_ready_at);
            chk("wr_en", rf_write_enable, e_we);
            chk("res_valid", res_valid, e_we);
            chk("wr_idx", rf_write_index, e_we ? m_rd : '0);
            chk("wr_data", rf_write_data, e_we ? m_val : '0);
            chk("rd_idx", rf_read_index, e_ridx);
            chk("carry", carry, m_carry);
            if (rf_write_enable) strobe_q.push_back(rf_write_data);
        end
    end

    task automatic randomize_fields();
        cmd_op = 2'($urandom); cmd_rd = IW'($urandom); cmd_rs1 = IW'($urandom);
        cmd_rs2 = IW'($urandom); cmd_imm = DW'($urandom);
    endtask

    task automatic send(input logic [1:0] op, input logic [IW-1:0] rd, rs1, rs2,
                        input logic [DW-1:0] imm);
        bit ok = 0;
        @(negedge clk); #1;
        cmd_valid = 1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (cmd_ready) begin @(posedge clk); #1; ok = 1; end
            else begin @(negedge clk); #1; end
        end
        cmd_valid = 0;
        randomize_fields();
        chk("accept", ok, 1);
    endtask

    task automatic wait_strobe(output int unsigned lat, output logic [DW-1:0] d,
                               output logic [IW-1:0] ix, output logic rv);
        bit got = 0;
        lat = 0; d = '0; ix = '0; rv = 0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (rf_write_enable) begin
                got = 1; lat = i; d = rf_write_data; ix = rf_write_index; rv = res_valid;
            end
        end
        chk("strobe_seen", got, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int unsigned   lat, acc1, acc2, n0;
        logic [DW-1:0] d;
        logic [IW-1:0] ix;
        logic          rv;
        bit            ok;

        repeat (3) @(posedge clk);
        #3 reset = 0;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1);

        // Asynchronous reset landing in a WRITE cycle suppresses the write.
        send(2'd0, 2'd0, 2'd0, 2'd0, 16'h5555);
        chk("pre_reset_we", rf_write_enable, 1);
        #2 reset = 1;
        #1;
        chk("async_we", rf_write_enable, 0);
        chk("async_data", rf_write_data, 0);
        chk("async_rv", res_valid, 0);
        repeat (3) @(posedge clk);
        #3 reset = 0;
        @(negedge clk);
        chk("abort_r0", rf[0], 16'h0000);
        chk("ready_release", cmd_ready, 1);

        send(2'd0, 2'd2, 2'd0, 2'd0, 16'h1234);
        wait_strobe(lat, d, ix, rv);
        chk("ldi_lat", lat, 1);
        chk("ldi_idx", ix, 2);
        chk("ldi_data", d, 16'h1234);
        chk("ldi_rv", rv, 1);
        @(negedge clk);
        chk("ldi_ready_back", cmd_ready, 1);

        send(2'd0, 2'd1, 2'd0, 2'd0, 16'hFFFF); wait_strobe(lat, d, ix, rv);
        send(2'd0, 2'd2, 2'd0, 2'd0, 16'h0002); wait_strobe(lat, d, ix, rv);
        send(2'd2, 2'd3, 2'd1, 2'd2, 16'h0000);
        @(negedge clk); chk("add_ridx1", rf_read_index, 1);
        @(negedge clk); chk("add_ridx2", rf_read_index, 2);
        @(negedge clk);
        chk("add_we", rf_write_enable, 1);
        chk("add_idx", rf_write_index, 3);
        chk("add_data", rf_write_data, 16'h0001);
        @(negedge clk); chk("add_carry", carry, 1);

        send(2'd0, 2'd1, 2'd0, 2'd0, 16'h0005); wait_strobe(lat, d, ix, rv);
        send(2'd0, 2'd2, 2'd0, 2'd0, 16'h0007); wait_strobe(lat, d, ix, rv);
        chk("ldi_keeps_carry", carry, 1);
        send(2'd3, 2'd0, 2'd1, 2'd2, 16'h0000); wait_strobe(lat, d, ix, rv);
        chk("sub1_lat", lat, 3);
        chk("sub1_data", d, 16'hFFFE);
        @(negedge clk); chk("sub1_borrow", carry, 1);
        send(2'd3, 2'd0, 2'd2, 2'd1, 16'h0000); wait_strobe(lat, d, ix, rv);
        chk("sub2_data", d, 16'h0002);
        @(negedge clk); chk("sub2_borrow", carry, 0);

        // cmd_valid held high: MOV r0=r3, then LDI r1=BEEF; busy-cycle field noise.
        n0 = strobe_q.size();
        acc1 = 0; acc2 = 0;
        @(negedge clk); #1;
        cmd_valid = 1; cmd_op = 2'd1; cmd_rd = 2'd0; cmd_rs1 = 2'd3; cmd_rs2 = 2'd0; cmd_imm = '0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (cmd_ready) begin @(posedge clk); #1; acc1 = cyc; ok = 1; end
            else begin @(negedge clk); #1; end
        end
        chk("hold_acc1", ok, 1);
        randomize_fields();
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1;
            if (cmd_ready) begin
                cmd_op = 2'd0; cmd_rd = 2'd1; cmd_imm = 16'hBEEF;
                @(posedge clk); #1; acc2 = cyc; ok = 1;
            end else randomize_fields();
        end
        cmd_valid = 0;
        chk("hold_acc2", ok, 1);
        chk("hold_spacing", acc2 - acc1, 3);
        repeat (4) @(negedge clk);
        chk("hold_strobes", strobe_q.size() - n0, 2);
        if (strobe_q.size() >= n0 + 2) begin
            chk("hold_mov_data", strobe_q[n0], 16'h0001);
            chk("hold_ldi_data", strobe_q[n0+1], 16'hBEEF);
        end

        // Abort during READ2 of an ADD.
        send(2'd0, 2'd1, 2'd0, 2'd0, 16'hFFFF); wait_strobe(lat, d, ix, rv);
        send(2'd0, 2'd2, 2'd0, 2'd0, 16'h0002); wait_strobe(lat, d, ix, rv);
        send(2'd2, 2'd3, 2'd1, 2'd2, 16'h0000); wait_strobe(lat, d, ix, rv);
        @(negedge clk); chk("pre_abort_carry", carry, 1);
        n0 = strobe_q.size();
        send(2'd2, 2'd0, 2'd1, 2'd2, 16'h0000);
        @(posedge clk);
        #2 reset = 1;
        #1;
        chk("abort_carry", carry, 0);
        repeat (3) @(posedge clk);
        #3 reset = 0;
        repeat (3) @(negedge clk);
        chk("abort_no_strobe", strobe_q.size() - n0, 0);
        chk("abort_r0_kept", rf[0], 16'h0001);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_carry_after", carry, 0);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk); #1;
            cmd_valid = ($urandom_range(0, 2) != 0);
            randomize_fields();
        end
        @(negedge clk); #1;
        cmd_valid = 0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) chk("final_reg", rf[i], m_regs[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
